// File: rtl/apf_interp2_32_pkg.sv
// Shared constants, default all-pass coefficients and FSM states for the
// polyphase all-pass interpolator/decimator family.
package apf_interp2_32_pkg;

  localparam int DATA_W    = 32;
  localparam int COEF_FRAC = 10;

  // Q.10 coefficients, identical to the decimator cascade
  localparam logic signed [DATA_W-1:0] A0_1_DEF = -32'sd208;
  localparam logic signed [DATA_W-1:0] A0_2_DEF = -32'sd930;
  localparam logic signed [DATA_W-1:0] A1_1_DEF = -32'sd1021;
  localparam logic signed [DATA_W-1:0] A1_2_DEF = -32'sd1010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S0   = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_S3   = 3'd4,
    ST_OUT0 = 3'd5,
    ST_OUT1 = 3'd6
  } state_e;

endpackage

// File: rtl/apf_mac_q10.sv
// Combinational first-order all-pass section:
// y = ((a * (x - y_prev)) >>> FRAC) + x_prev, wrapping, floor shift.
module apf_mac_q10
  import apf_interp2_32_pkg::*;
#(
  parameter int FRAC = COEF_FRAC
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] x_prev,
  input  logic signed [DATA_W-1:0] y_prev,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0]   diff;
  logic signed [2*DATA_W-1:0] prod;

  always_comb begin
    diff = x - y_prev;
    prod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{diff[DATA_W-1]}}, diff});
    y    = DATA_W'(prod >>> FRAC) + x_prev;
  end

endmodule

// File: rtl/apf_interp2_32.sv
// 2x polyphase all-pass interpolator: one input sample yields branch 0 then
// branch 1 outputs, all four sections sharing a single multiplier.
module apf_interp2_32
  import apf_interp2_32_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] A0_1 = A0_1_DEF,
  parameter logic signed [DATA_W-1:0] A0_2 = A0_2_DEF,
  parameter logic signed [DATA_W-1:0] A1_1 = A1_1_DEF,
  parameter logic signed [DATA_W-1:0] A1_2 = A1_2_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [DATA_W-1:0] x_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] y_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_e state_q, state_d;
  logic                     rdy_en_q;
  logic signed [DATA_W-1:0] x_lat_q, x_lat_d;
  logic signed [DATA_W-1:0] mid_q, mid_d;
  logic signed [DATA_W-1:0] b0_q, b0_d;
  logic signed [DATA_W-1:0] b1_q, b1_d;
  logic signed [DATA_W-1:0] y_out_q, y_out_d;
  logic signed [DATA_W-1:0] xd_q [4];
  logic signed [DATA_W-1:0] xd_d [4];
  logic signed [DATA_W-1:0] yd_q [4];
  logic signed [DATA_W-1:0] yd_d [4];

  logic [1:0]               sec;
  logic signed [DATA_W-1:0] mac_a, mac_x, mac_xp, mac_yp, mac_y;

  // Operand muxes for the shared section datapath
  always_comb begin
    sec   = 2'd0;
    mac_x = x_lat_q;
    case (state_q)
      ST_S1:   begin sec = 2'd1; mac_x = mid_q; end
      ST_S2:   begin sec = 2'd2; mac_x = x_lat_q; end
      ST_S3:   begin sec = 2'd3; mac_x = mid_q; end
      default: begin sec = 2'd0; mac_x = x_lat_q; end
    endcase
    case (sec)
      2'd0:    mac_a = A0_1;
      2'd1:    mac_a = A0_2;
      2'd2:    mac_a = A1_1;
      default: mac_a = A1_2;
    endcase
    mac_xp = xd_q[sec];
    mac_yp = yd_q[sec];
  end

  apf_mac_q10 #(.FRAC(COEF_FRAC)) u_mac (
    .a      (mac_a),
    .x      (mac_x),
    .x_prev (mac_xp),
    .y_prev (mac_yp),
    .y      (mac_y)
  );

  always_comb begin
    state_d  = state_q;
    x_lat_d  = x_lat_q;
    mid_d    = mid_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    y_out_d  = y_out_q;
    xd_d     = xd_q;
    yd_d     = yd_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          for (int i = 0; i < 4; i++) begin
            xd_d[i] = '0;
            yd_d[i] = '0;
          end
        end else begin
          in_ready = rdy_en_q;
          if (in_valid && rdy_en_q) begin
            x_lat_d = x_in;
            state_d = ST_S0;
          end
        end
      end
      ST_S0: begin
        xd_d[0] = mac_x;  yd_d[0] = mac_y;
        mid_d   = mac_y;
        state_d = ST_S1;
      end
      ST_S1: begin
        xd_d[1] = mac_x;  yd_d[1] = mac_y;
        b0_d    = mac_y;
        state_d = ST_S2;
      end
      ST_S2: begin
        xd_d[2] = mac_x;  yd_d[2] = mac_y;
        mid_d   = mac_y;
        state_d = ST_S3;
      end
      ST_S3: begin
        xd_d[3] = mac_x;  yd_d[3] = mac_y;
        b1_d    = mac_y;
        y_out_d = b0_q;
        state_d = ST_OUT0;
      end
      ST_OUT0: begin
        if (out_ready) begin
          y_out_d = b1_q;
          state_d = ST_OUT1;
        end
      end
      ST_OUT1: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rdy_en_q keeps in_ready low while reset is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
      x_lat_q  <= '0;
      mid_q    <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      y_out_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        xd_q[i] <= '0;
        yd_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      x_lat_q  <= x_lat_d;
      mid_q    <= mid_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      y_out_q  <= y_out_d;
      for (int i = 0; i < 4; i++) begin
        xd_q[i] <= xd_d[i];
        yd_q[i] <= yd_d[i];
      end
    end
  end

  assign y_out     = y_out_q;
  assign out_valid = (state_q == ST_OUT0) || (state_q == ST_OUT1);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apf_interp2_32.sv
// Directed self-checking bench for apf_interp2_32.
module tb_apf_interp2_32;

  logic        clk;
  logic        reset;
  logic        clr;
  logic [31:0] x_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  int mx [4];
  int my [4];
  int ma [4] = '{-208, -930, -1021, -1010};

  apf_interp2_32 dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int sec_f(int a, int x, int xp, int yp);
    int     d;
    longint p;
    d = x - yp;
    p = longint'(a) * longint'(d);
    p = p >>> 10;
    return int'(p) + xp;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
  endtask

  task automatic model_step(input int x, output int e0, output int e1);
    int s [4];
    int xi [4];
    xi[0] = x;
    s[0]  = sec_f(ma[0], xi[0], mx[0], my[0]);
    xi[1] = s[0];
    s[1]  = sec_f(ma[1], xi[1], mx[1], my[1]);
    xi[2] = x;
    s[2]  = sec_f(ma[2], xi[2], mx[2], my[2]);
    xi[3] = s[2];
    s[3]  = sec_f(ma[3], xi[3], mx[3], my[3]);
    for (int i = 0; i < 4; i++) begin
      mx[i] = xi[i];
      my[i] = s[i];
    end
    e0 = s[1];
    e1 = s[3];
  endtask

  task automatic run_sample(input string tag, input logic [31:0] x, input int hold,
                            input logic [31:0] e0, input logic [31:0] e1);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    x_in      = x;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = $urandom;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, n, 32'd4);
    check({tag, "_y0"}, y_out, e0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_y0"}, y_out, e0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid1"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_y1"}, y_out, e1);
    @(posedge clk); #1;
    check({tag, "_valid_done"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready_again"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    #1;
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
  endtask

  initial begin
    int e0, e1;
    reset     = 1'b0;
    clr       = 1'b0;
    x_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    model_clear();

    // reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      x_in      = $urandom;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      clr       = 1'($urandom_range(0, 1));
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_y_out", y_out, 32'd0);
    check("rel_busy", {31'd0, busy}, 32'd0);

    // impulse response, first two samples
    model_step(1024, e0, e1);
    run_sample("imp1024", 32'd1024, 0, 32'd188, 32'd1007);
    model_step(0, e0, e1);
    run_sample("imp0", 32'd0, 0, -32'sd929, -32'sd33);

    // clr then impulse under backpressure
    pulse_clr();
    model_step(1024, e0, e1);
    run_sample("bp", 32'd1024, 10, 32'd188, 32'd1007);

    // wrap and floor at the extremes
    pulse_clr();
    model_step(32'h7FFF_FFFF, e0, e1);
    run_sample("wrap_max", 32'h7FFF_FFFF, 0, e0, e1);
    model_step(32'h8000_0000, e0, e1);
    run_sample("wrap_min", 32'h8000_0000, 2, e0, e1);

    // reset during S2 discards the sample and clears state
    x_in     = 32'd1024;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy_s2", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_out", {31'd0, out_valid}, 32'd0);
    end
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_out", {31'd0, out_valid}, 32'd0);
    end
    model_step(1024, e0, e1);
    run_sample("post_rst_imp", 32'd1024, 0, 32'd188, 32'd1007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apf_interp2_32.md
Name: apf_interp2_32

Overview:
- 2x polyphase all-pass interpolator. It is the upsampling counterpart of the all-pass decimation filter cascade.
- Each accepted 32-bit input sample is pushed through two all-pass branches, each a cascade of two first-order all-pass sections. The block then emits two output samples: branch 0 first, then branch 1.
- A single time-multiplexed multiplier serves all four sections.
- Sits between the sample-rate-fs producer and the 2·fs DAC/output path, using valid/ready handshakes on both sides.

Parameters:
- COEF_FRAC, 10, fractional bits of the coefficients (Q.10).
- A0_1, -208, branch 0 section 1 coefficient (signed 32-bit).
- A0_2, -930, branch 0 section 2 coefficient.
- A1_1, -1021, branch 1 section 1 coefficient.
- A1_2, -1010, branch 1 section 2 coefficient.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of all delay-line state; sampled only in IDLE.
- x_in  in  32  signed input sample.
- in_valid  in  1  x_in valid.
- in_ready  out  1  block can accept a sample.
- y_out  out  32  signed output sample.
- out_valid  out  1  y_out valid.
- out_ready  in  1  consumer accepts y_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Section equation, with a = coefficient: y[n] = ((a * (x[n] - y[n-1])) >>> COEF_FRAC) + x[n-1].
  - Each section keeps its own x[n-1] and y[n-1] registers: 4 sections, 8 registers of 32 bits.
- Arithmetic:
  - Subtraction and addition are 32-bit two's complement, wrapping modulo 2^32.
  - The product is a full 64-bit signed value; the arithmetic right shift floors toward -inf; the result is truncated to 32 bits.
  - No saturation and no rounding.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all delay registers, y_out and the branch result registers go to 0.
  - in_ready=0 while reset is asserted, then 1 in IDLE; out_valid=0; busy=0.
  - Reset mid-computation or mid-output discards the sample in flight; no partial output is emitted.
- FSM states: IDLE, S0, S1, S2, S3, OUT0, OUT1.
  - IDLE, clr=1: clear the delay registers; in_ready=0 that cycle.
  - IDLE, clr=0: in_ready=1. On in_valid&in_ready, latch x_in and go to S0.
  - S0: branch 0 section 1 on the latched x. Update its x/y delays. Store the result.
  - S1: branch 0 section 2 on the S0 result. Store it as b0.
  - S2: branch 1 section 1 on the latched x.
  - S3: branch 1 section 2 on the S2 result. Store it as b1. Go to OUT0.
  - OUT0: y_out=b0, out_valid=1. Hold until out_ready, then go to OUT1.
  - OUT1: y_out=b1, out_valid=1. Hold until out_ready, then go to IDLE.
- Latency: with out_ready held high, a sample accepted at edge k gives out_valid for b0 in cycle k+5 and b1 in cycle k+6. in_ready rises again in cycle k+7.
  - Throughput is therefore 1 input per 7 cycles minimum.
- Backpressure: y_out and out_valid stay stable while out_valid=1 and out_ready=0. in_ready=0 outside IDLE.
- in_valid outside IDLE is ignored: no data is lost, because the producer must hold it.
- One multiplier instance: its operand muxes are selected by the section index. Delay registers update only in their own section cycle.
- clr outside IDLE has no effect.

Decomposition:
- Shared package:
  - DATA_W=32 and COEF_FRAC=10.
  - The FSM state enumeration.
  - Default coefficient constants, shared with the decimator cascade.
- One natural sub-module: apf_mac_q10. It is combinational: inputs a, x, x_prev, y_prev; output the section result under the rules above. It is reused by any future time-multiplexed all-pass block.

Test Plan:
- Reset: hold reset=0 with random inputs -> out_valid=0, busy=0, in_ready=0. Release -> in_ready=1, y_out=0.
- Impulse: x=1024, out_ready=1.
  - Outputs 188 then 1007, in cycles k+5 and k+6.
  - Next input x=0 -> branch 0 output -929.
- Backpressure: hold out_ready=0 for 10 cycles in OUT0 -> y_out stays 188 and out_valid stays 1, with no progress. Release -> 1007 follows.
- Wrap and floor: x=32'h7FFFFFFF, then x=32'h80000000 -> outputs match a bit-exact reference model with 64-bit product, floor shift and 32-bit wrap.
- Mid-operation reset: assert reset in S2 -> no output beats. After release, the impulse test reproduces 188/1007, showing the delay registers were cleared.
- clr: after the impulse, pulse clr in IDLE, then input x=1024 -> outputs 188/1007 again, not the continued impulse response.
